// File: rtl/led_seq_ctrl.sv
// LED sequencer: OFF / ON / BLINK / 8-bit PATTERN with repeat count, stepped by a prescaled tick.
// Optional build macro LED_SEQ_PREEMPT_EN lets a new command preempt a running sequence.
module led_seq_ctrl #(
   parameter int unsigned CLK_FREQ_HZ = 27_000_000,
   parameter int unsigned TICK_HZ     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_mode,
   input  logic [7:0] cmd_pattern,
   input  logic [3:0] cmd_repeat,
   output logic       led_out,
   output logic       busy,
   output logic       done
);

   localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ - 1;
   localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
   localparam int unsigned STEP_W   = 3;
   localparam int unsigned REP_W    = 4;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_PATTERN = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [STEP_W-1:0]   step, step_nx;
   logic [REP_W-1:0]    rep_cnt, rep_nx;
   logic [1:0]          mode_q, mode_nx;
   logic [7:0]          pattern_q, pattern_nx;
   logic                led_nx, busy_nx, done_nx;
   logic                xfer, tick, last_step;

   // LED level for a given step of a running BLINK or PATTERN sequence
   function automatic logic step_level(input logic [1:0]        mode,
                                       input logic [7:0]        pattern,
                                       input logic [STEP_W-1:0] idx);
      logic lvl;
      lvl = 1'b0;
      if (mode == MODE_BLINK)
         lvl = ~idx[0];
      else if (mode == MODE_PATTERN)
         lvl = pattern[STEP_W'(3'd7 - idx)];
      return lvl;
   endfunction

`ifdef LED_SEQ_PREEMPT_EN
   assign cmd_ready = !rst;
`else
   assign cmd_ready = (state == S_IDLE) && !rst;
`endif

   assign xfer      = cmd_valid && cmd_ready;
   assign tick      = (cnt == CNT_W'(TICK_DIV));
   assign last_step = (mode_q == MODE_BLINK) ? (step == STEP_W'(1)) : (step == STEP_W'(7));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         step      <= '0;
         rep_cnt   <= '0;
         mode_q    <= MODE_OFF;
         pattern_q <= '0;
         led_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         step      <= step_nx;
         rep_cnt   <= rep_nx;
         mode_q    <= mode_nx;
         pattern_q <= pattern_nx;
         led_out   <= led_nx;
         busy      <= busy_nx;
         done      <= done_nx;
      end
   end

   // Next state and next register values; a transfer overrides whatever the current state does
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      step_nx    = step;
      rep_nx     = rep_cnt;
      mode_nx    = mode_q;
      pattern_nx = pattern_q;
      led_nx     = led_out;

      if (xfer) begin
         mode_nx    = cmd_mode;
         pattern_nx = cmd_pattern;
         rep_nx     = cmd_repeat;
         cnt_nx     = '0;
         step_nx    = '0;
         case (cmd_mode)
            MODE_OFF: begin
               led_nx   = 1'b0;
               state_nx = S_FINISH;
            end
            MODE_ON: begin
               led_nx   = 1'b1;
               state_nx = S_FINISH;
            end
            default: begin
               led_nx   = step_level(cmd_mode, cmd_pattern, STEP_W'(0));
               state_nx = S_RUN;
            end
         endcase
      end else begin
         case (state)
            S_IDLE: begin
               cnt_nx = '0;
            end
            S_RUN: begin
               if (tick) begin
                  cnt_nx = '0;
                  if (last_step) begin
                     step_nx = '0;
                     if (rep_cnt == REP_W'(1)) begin
                        // Final step of the final repeat: LED off as FINISH is entered
                        rep_nx   = '0;
                        led_nx   = 1'b0;
                        state_nx = S_FINISH;
                     end else begin
                        // A zero repeat count means run forever, so it is never decremented
                        if (rep_cnt != '0)
                           rep_nx = rep_cnt - REP_W'(1);
                        led_nx = step_level(mode_q, pattern_q, STEP_W'(0));
                     end
                  end else begin
                     step_nx = step + STEP_W'(1);
                     led_nx  = step_level(mode_q, pattern_q, step + STEP_W'(1));
                  end
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            S_FINISH: begin
               cnt_nx   = '0;
               state_nx = S_IDLE;
            end
            default: begin
               cnt_nx   = '0;
               step_nx  = '0;
               led_nx   = 1'b0;
               state_nx = S_IDLE;
            end
         endcase
      end

      busy_nx = (state_nx == S_RUN);
      done_nx = (state_nx == S_FINISH);
   end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed table-driven bench for led_seq_ctrl at CLK_FREQ_HZ=16, TICK_HZ=4 (4 cycles per step).
module tb_led_seq_ctrl;

   localparam logic [1:0] M_OFF = 2'd0;
   localparam logic [1:0] M_ON  = 2'd1;
   localparam logic [1:0] M_BLK = 2'd2;
   localparam logic [1:0] M_PAT = 2'd3;

`ifdef LED_SEQ_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_mode = 2'd0;
   logic [7:0] cmd_pattern = 8'd0;
   logic [3:0] cmd_repeat = 4'd0;
   logic       led_out, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   led_seq_ctrl #(.CLK_FREQ_HZ(16), .TICK_HZ(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_mode    (cmd_mode),
      .cmd_pattern (cmd_pattern),
      .cmd_repeat  (cmd_repeat),
      .led_out     (led_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Each row: inputs held for n cycles; outputs checked #1 after every edge.
   // rdy is the expectation for the non-preempt build; with preemption cmd_ready = !rst.
   typedef struct {
      logic       rst;
      logic       valid;
      logic [1:0] mode;
      logic [7:0] pat;
      logic [3:0] rep;
      int         n;
      logic       led;
      logic       busy;
      logic       done;
      logic       rdy;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic v, input logic [1:0] m,
                               input logic [7:0] p, input logic [3:0] rp, input int n,
                               input logic l, input logic b, input logic d, input logic rd);
      vec_t x;
      x.rst = r; x.valid = v; x.mode = m; x.pat = p; x.rep = rp; x.n = n;
      x.led = l; x.busy = b; x.done = d; x.rdy = rd;
      tbl.push_back(x);
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int run_len;

      // Reset, then ready on the first cycle after reset
      add(1,0,M_OFF,8'h00,4'd0, 2, 0,0,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,0,1);
      // BLINK repeat=2: 1,0,1,0 in 4-cycle blocks, done on cycle 17
      add(0,1,M_BLK,8'hFF,4'd2, 1, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 3, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,1,0);
      add(0,0,M_OFF,8'h00,4'd0, 2, 0,0,0,1);
      // PATTERN 10110000 repeat=1, done on cycle 33
      add(0,1,M_PAT,8'b10110000,4'd1, 1, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 3, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 8, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 16, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,1,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,0,1);
      // ON (repeat ignored) held through 20 idle cycles, then OFF
      add(0,1,M_ON, 8'h00,4'd5, 1, 1,0,1,0);
      add(0,0,M_OFF,8'h00,4'd0, 20, 1,0,0,1);
      add(0,1,M_OFF,8'hFF,4'd0, 1, 0,0,1,0);
      add(0,0,M_OFF,8'h00,4'd0, 2, 0,0,0,1);
      // BLINK repeat=0, ON presented at cycle 10
      add(0,1,M_BLK,8'h00,4'd0, 1, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 3, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 2, 1,1,0,0);
`ifdef LED_SEQ_PREEMPT_EN
      add(0,1,M_ON, 8'h00,4'd0, 1, 1,0,1,1);
      add(0,0,M_OFF,8'h00,4'd0, 2, 1,0,0,1);
`else
      add(0,1,M_ON, 8'h00,4'd0, 2, 1,1,0,0);
      add(0,1,M_ON, 8'h00,4'd0, 4, 0,1,0,0);
      add(0,1,M_ON, 8'h00,4'd0, 4, 1,1,0,0);
      add(1,0,M_OFF,8'h00,4'd0, 1, 0,0,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,0,1);
      // ON held during a BLINK repeat=1 is taken on the first IDLE cycle
      add(0,1,M_BLK,8'h00,4'd1, 1, 1,1,0,0);
      add(0,1,M_ON, 8'h00,4'd0, 3, 1,1,0,0);
      add(0,1,M_ON, 8'h00,4'd0, 4, 0,1,0,0);
      add(0,1,M_ON, 8'h00,4'd0, 1, 0,0,1,0);
      add(0,1,M_ON, 8'h00,4'd0, 1, 0,0,0,1);
      add(0,1,M_ON, 8'h00,4'd0, 1, 1,0,1,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 1,0,0,1);
`endif
      // PATTERN 11001010 repeat=3 reset at cycle 20: no done, then a new command runs
      add(0,1,M_PAT,8'b11001010,4'd3, 1, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 7, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 8, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 1,1,0,0);
      add(1,0,M_OFF,8'h00,4'd0, 1, 0,0,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 3, 0,0,0,1);
      add(0,1,M_BLK,8'h00,4'd1, 1, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 3, 1,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 4, 0,1,0,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,1,0);
      add(0,0,M_OFF,8'h00,4'd0, 1, 0,0,0,1);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int c = 0; c < tbl[i].n; c++) begin
            rst         = tbl[i].rst;
            cmd_valid   = tbl[i].valid;
            cmd_mode    = tbl[i].mode;
            cmd_pattern = tbl[i].pat;
            cmd_repeat  = tbl[i].rep;
            tick_sample();
            check($sformatf("row%0d.c%0d led_out", i, c), led_out, tbl[i].led);
            check($sformatf("row%0d.c%0d busy", i, c), busy, tbl[i].busy);
            check($sformatf("row%0d.c%0d done", i, c), done, tbl[i].done);
            check($sformatf("row%0d.c%0d cmd_ready", i, c), cmd_ready,
                  PREEMPT ? !tbl[i].rst : tbl[i].rdy);
         end
      end
      rst = 1'b0; cmd_valid = 1'b0;
      tick_sample();

      // RUN length for PATTERN repeat=2 is 2*8*4 = 64 cycles
      cmd_valid = 1'b1; cmd_mode = M_PAT; cmd_pattern = 8'hA5; cmd_repeat = 4'd2;
      tick_sample();
      cmd_valid = 1'b0;
      run_len = 0;
      while (busy && run_len < 200) begin
         run_len++;
         tick_sample();
      end
      check_int("pattern_run_len", run_len, 64);
      check("pattern_end done", done, 1'b1);
      check("pattern_end led_out", led_out, 1'b0);
      tick_sample();
      check("after_finish done", done, 1'b0);

      // Reset wins over a simultaneous transfer; cmd_ready low during reset
      rst = 1'b1; cmd_valid = 1'b1; cmd_mode = M_ON;
      #1;
      check("rst_prio cmd_ready", cmd_ready, 1'b0);
      tick_sample();
      check("rst_prio led_out", led_out, 1'b0);
      check("rst_prio done", done, 1'b0);
      rst = 1'b0; cmd_valid = 1'b0;
      tick_sample();
      check("rst_prio post led_out", led_out, 1'b0);
      check("rst_prio post done", done, 1'b0);
      check("rst_prio post cmd_ready", cmd_ready, 1'b1);

      // Reset mid-RUN aborts with no done pulse
      cmd_valid = 1'b1; cmd_mode = M_BLK; cmd_repeat = 4'd0;
      tick_sample();
      cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort busy_before", busy, 1'b1);
      rst = 1'b1;
      tick_sample();
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort led_out", led_out, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick_sample();
         check($sformatf("abort no_done.%0d", k), done, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 27_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 8, sequencer step rate in Hz; TICK_DIV = CLK_FREQ_HZ/TICK_HZ - 1, and TICK_DIV SHALL be >= 1.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accept; a transfer SHALL occur when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 cmd_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=PATTERN.
REQ-008 cmd_pattern  input  8  PATTERN bits, MSB first; ignored in other modes.
REQ-009 cmd_repeat  input  4  repeat count for BLINK/PATTERN; 0 = infinite.
REQ-010 led_out  output  1  LED drive, active high.
REQ-011 busy  output  1  high while state is RUN.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and FINISH; cmd_mode, cmd_pattern and cmd_repeat SHALL be latched on transfer.
REQ-014 Prescaler: the counter SHALL count 0..TICK_DIV and wrap to 0; tick = (count == TICK_DIV); the counter SHALL clear to 0 on every transfer so that the first step lasts exactly TICK_DIV+1 cycles.
REQ-015 OFF/ON: led_out SHALL take 0/1 on the cycle after transfer and the FSM SHALL go to FINISH; led_out SHALL hold that level in IDLE until the next command.
REQ-016 BLINK: one repeat SHALL be 2 steps, with led_out=1 then led_out=0; the FSM SHALL enter RUN on the cycle after transfer, with led_out=1 on that same cycle.
REQ-017 PATTERN: one repeat SHALL be 8 steps; led_out SHALL equal cmd_pattern[7-i] during step i; the first bit SHALL appear on the cycle after transfer.
REQ-018 Each step SHALL advance on tick; the step index SHALL wrap at the end of each repeat, and the repeat counter SHALL decrement at that point.
REQ-019 On the tick that ends the last step of repeat number cmd_repeat (cmd_repeat != 0), the FSM SHALL move RUN->FINISH and led_out SHALL go to 0 in the same cycle.
REQ-020 With cmd_repeat = 0, RUN SHALL never end on its own; it ends only by reset or by preemption (REQ-029).
REQ-021 FINISH SHALL last exactly 1 cycle, with done=1 and busy=0, then go to IDLE.
REQ-022 busy SHALL be 1 exactly when state = RUN; done SHALL be 1 exactly when state = FINISH.
REQ-023 Total RUN length SHALL be cmd_repeat*steps*(TICK_DIV+1) cycles.

Reset
REQ-024 While rst is high at a rising edge: state=IDLE, prescaler=0, step index=0, repeat counter=0, led_out=0, busy=0, done=0.
REQ-025 Reset SHALL take priority over a simultaneous transfer; the command SHALL be dropped.
REQ-026 Reset during RUN SHALL abort the sequence without a done pulse.
REQ-027 cmd_ready SHALL be 0 while rst is high.

Configuration
REQ-028 Macro LED_SEQ_PREEMPT_EN undefined: cmd_ready = (state == IDLE) && !rst; a cmd_valid held during RUN or FINISH SHALL be accepted on the first IDLE cycle.
REQ-029 Macro LED_SEQ_PREEMPT_EN defined: cmd_ready = !rst in every state.
- A transfer during RUN SHALL restart immediately with the new command and SHALL give no done pulse for the preempted command.
- A transfer during FINISH SHALL still show done=1 in that cycle, then start the new command.

Verification (CLK_FREQ_HZ=16, TICK_HZ=4 -> TICK_DIV=3, 4 cycles/step)
REQ-030 Reset for 2 cycles -> led_out=0, busy=0, done=0, cmd_ready=1 on the first cycle after reset.
REQ-031 BLINK, repeat=2, accepted at cycle 0 -> led_out 1,0,1,0 in 4-cycle blocks over cycles 1-16; busy=1 on cycles 1-16; done=1 on cycle 17 only; led_out=0 from cycle 17.
REQ-032 PATTERN 8'b10110000, repeat=1 -> led_out per 4-cycle block 1,0,1,1,0,0,0,0 over cycles 1-32; done on cycle 33.
REQ-033 ON -> led_out=1 from cycle 1 with done on cycle 1, held through 20 idle cycles; then OFF -> led_out=0 on the next cycle with done.
REQ-034 BLINK repeat=0 running, second command (ON) presented at cycle 10:
- Without the macro: cmd_ready=0 and the blink continues.
- With the macro: accepted at cycle 10, led_out=1 at cycle 11, done at cycle 11, and no done for the blink.
REQ-035 PATTERN repeat=3, rst=1 at cycle 20 -> all outputs reset values at cycle 21; no done; a new command is accepted after rst is released.
